// File: rtl/regfile_mp.sv
// Multi-port register file with a merging write port, registered read ports and a post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN: same-edge read of the written entry returns the merged new value.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [1:0]                 wr_mode,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       init_busy,
    output logic                       mode_err
);

    // state    | meaning
    // ST_CLEAR | zeroing entry[clr_cnt] each edge, writes refused
    // ST_RUN   | normal operation until next reset

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hffff);
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hff);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_q [NUM_RD];
    logic [DATA_W-1:0]   rd_next [NUM_RD];
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_new;
    logic                wr_accept;
    logic                wr_zero;
    logic                wr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    assign init_busy = (state_q == ST_CLEAR);
    assign wr_ready  = ~init_busy;
    assign wr_accept = wr_valid && wr_ready;
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_we     = wr_accept && (wr_mode != 2'b11) && !wr_zero;
    assign wr_old    = mem[wr_addr];

    always_comb begin
        wr_new = wr_data;
        case (wr_mode)
            2'b01:   wr_new = (wr_old & ~HALF_MASK) | (wr_data & HALF_MASK);
            2'b10:   wr_new = (wr_old & ~BYTE_MASK) | (wr_data & BYTE_MASK);
            default: wr_new = wr_data;
        endcase
    end

    // Array itself has no reset; the clear sequencer provides known contents.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_we) begin
            mem[wr_addr] <= wr_new;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
            if (BYPASS && wr_we && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_next[i] = wr_new;
            end
            if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
                rd_next[i] = '0;
            end
            if (init_busy) begin
                rd_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) rd_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) rd_q[i] <= rd_next[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
        assign rd_data[g*DATA_W +: DATA_W] = rd_q[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_err <= 1'b0;
        end else if (wr_accept && (wr_mode == 2'b11)) begin
            mode_err <= 1'b1;
        end
    end

endmodule
